// File: rtl/pipe_event_counter_if.sv
// Control/readout bundle for pipe_event_counter: run control and event strobes in,
// registered counter readout and status out.
interface pipe_event_counter_if #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);

  logic                  start_i;
  logic                  clear_i;
  logic                  freeze_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic [NUM_EVENTS-1:0] mask_i;
  logic [SEL_W-1:0]      sel_i;
  logic [CNT_WIDTH-1:0]  rd_data_o;
  logic [CNT_WIDTH-1:0]  cycle_o;
  logic                  running_o;
  logic                  done_o;
  logic [NUM_EVENTS-1:0] ovf_o;

  modport master (
    output start_i, clear_i, freeze_i, event_i, mask_i, sel_i,
    input  rd_data_o, cycle_o, running_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, clear_i, freeze_i, event_i, mask_i, sel_i,
    output rd_data_o, cycle_o, running_o, done_o, ovf_o
  );
endinterface

// File: rtl/pipe_event_counter.sv
// Cycle + qualified hazard-event counter over a bounded/unbounded run window,
// with per-channel saturating counters and a registered select readout.
module pipe_event_counter_lane #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      // a qualified event at all-ones is lost, so flag it instead of wrapping
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module pipe_event_counter #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipe_event_counter_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CYC = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] rd_q, rd_d;
  logic                 count_en;
  logic [NUM_EVENTS-1:0]                inc;
  logic [NUM_EVENTS-1:0]                ovf;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] ev_cnt;

  assign count_en = (state_q == S_RUN) && !bus.freeze_i && !bus.clear_i;
  assign inc      = {NUM_EVENTS{count_en}} & bus.event_i & bus.mask_i;

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    if (bus.clear_i) begin
      state_d = S_IDLE;
      cycle_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start_i) state_d = S_RUN;
        S_RUN: if (!bus.freeze_i) begin
          // unbounded runs saturate; bounded runs stop at MAX_CYCLES first
          if (!(MAX_CYCLES == 0 && (&cycle_q))) cycle_d = cycle_q + 1'b1;
          if (MAX_CYCLES != 0 && cycle_q == LAST_CYC) state_d = S_DONE;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  pipe_event_counter_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane [NUM_EVENTS-1:0] (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.clear_i),
    .inc_i (inc),
    .cnt_o (ev_cnt),
    .ovf_o (ovf)
  );

  // readout samples pre-update counter values; out-of-range selects read zero
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_EVENTS; i++)
      if (bus.sel_i == SEL_W'(i)) rd_d = ev_cnt[i];
    if (bus.sel_i == SEL_W'(NUM_EVENTS)) rd_d = cycle_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign bus.rd_data_o = rd_q;
  assign bus.cycle_o   = cycle_q;
  assign bus.running_o = (state_q == S_RUN);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.ovf_o     = ovf;
endmodule

// File: tb/tb_pipe_event_counter.sv
// Directed bench: bounded window on dut_a (32b, 64 cycles), saturation on dut_b (8b, unbounded).
module tb_pipe_event_counter;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_event_counter_if #(.NUM_EVENTS(4), .CNT_WIDTH(32)) bus_a ();
  pipe_event_counter_if #(.NUM_EVENTS(4), .CNT_WIDTH(8))  bus_b ();

  pipe_event_counter #(.NUM_EVENTS(4), .CNT_WIDTH(32), .MAX_CYCLES(64)) dut_a (
    .clk_i (clk), .rst_i (rst_a), .bus (bus_a)
  );
  pipe_event_counter #(.NUM_EVENTS(4), .CNT_WIDTH(8), .MAX_CYCLES(0)) dut_b (
    .clk_i (clk), .rst_i (rst_b), .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change 1ns after the edge, outputs are sampled at the same point
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.start_i = 0; bus_a.clear_i = 0; bus_a.freeze_i = 0;
    bus_a.event_i = '0; bus_a.mask_i = 4'b1111; bus_a.sel_i = '0;
    bus_b.start_i = 0; bus_b.clear_i = 0; bus_b.freeze_i = 0;
    bus_b.event_i = '0; bus_b.mask_i = 4'b1111; bus_b.sel_i = '0;
    step(2);
    rst_a = 1'b0; rst_b = 1'b0;

    chk("rst_rd",      bus_a.rd_data_o, 0);
    chk("rst_cycle",   bus_a.cycle_o,   0);
    chk("rst_running", bus_a.running_o, 0);
    chk("rst_done",    bus_a.done_o,    0);
    chk("rst_ovf",     bus_a.ovf_o,     0);

    // reset mid-run
    bus_a.start_i = 1; bus_a.event_i = 4'b0001;
    step(1);
    bus_a.start_i = 0;
    chk("start_no_count", bus_a.cycle_o, 0);
    step(10);
    chk("mid_cycle",   bus_a.cycle_o,   10);
    chk("mid_running", bus_a.running_o, 1);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    chk("mrst_cycle",   bus_a.cycle_o,   0);
    chk("mrst_running", bus_a.running_o, 0);
    chk("mrst_rd",      bus_a.rd_data_o, 0);
    bus_a.event_i = 4'b0000;
    step(2);
    chk("idle_hold", bus_a.cycle_o, 0);

    // full window: ch0 every cycle, ch1 every other cycle
    bus_a.start_i = 1;
    step(1);
    bus_a.start_i = 0;
    for (int k = 0; k < 64; k++) begin
      bus_a.event_i = {2'b00, (k % 2 == 0), 1'b1};
      step(1);
      if (k == 62) chk("win_not_done", bus_a.done_o, 0);
    end
    chk("win_done",    bus_a.done_o,    1);
    chk("win_running", bus_a.running_o, 0);
    chk("win_cycle",   bus_a.cycle_o,   64);
    bus_a.event_i = 4'b1111; bus_a.start_i = 1;
    bus_a.sel_i = 0; step(1); chk("win_sel0", bus_a.rd_data_o, 64);
    bus_a.start_i = 0;
    bus_a.sel_i = 1; step(1); chk("win_sel1", bus_a.rd_data_o, 32);
    bus_a.sel_i = 4; step(1); chk("win_sel4", bus_a.rd_data_o, 64);
    bus_a.sel_i = 5; step(1); chk("win_sel5", bus_a.rd_data_o, 0);
    bus_a.sel_i = 0; step(1); chk("done_hold0", bus_a.rd_data_o, 64);
    chk("done_cycle", bus_a.cycle_o, 64);
    chk("done_state", bus_a.done_o,  1);
    chk("done_ovf",   bus_a.ovf_o,   0);

    // clear + start together in DONE
    bus_a.clear_i = 1; bus_a.start_i = 1;
    step(1);
    bus_a.clear_i = 0; bus_a.start_i = 0;
    chk("clr_running", bus_a.running_o, 0);
    chk("clr_done",    bus_a.done_o,    0);
    chk("clr_cycle",   bus_a.cycle_o,   0);
    step(1);
    chk("clr_rd0", bus_a.rd_data_o, 0);
    bus_a.start_i = 1;
    step(1);
    bus_a.start_i = 0;
    chk("restart_running", bus_a.running_o, 1);

    // mask and freeze
    bus_a.mask_i = 4'b0010; bus_a.event_i = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      bus_a.freeze_i = (k >= 5 && k < 10);
      step(1);
    end
    bus_a.event_i = 4'b0000; bus_a.freeze_i = 1;
    chk("mf_cycle", bus_a.cycle_o, 15);
    chk("mf_done",  bus_a.done_o,  0);
    bus_a.start_i = 1;
    bus_a.sel_i = 0; step(1); chk("mf_ch0", bus_a.rd_data_o, 0);
    bus_a.start_i = 0;
    chk("start_ign_run", bus_a.running_o, 1);
    bus_a.sel_i = 1; step(1); chk("mf_ch1",   bus_a.rd_data_o, 15);
    bus_a.sel_i = 4; step(1); chk("mf_cycrd", bus_a.rd_data_o, 15);

    // saturation on the 8-bit unbounded instance
    bus_b.start_i = 1;
    step(1);
    bus_b.start_i = 0; bus_b.event_i = 4'b0100;
    step(255);
    chk("sat_cycle255", bus_b.cycle_o, 255);
    chk("sat_no_ovf",   bus_b.ovf_o,   0);
    step(1);
    chk("sat_ovf256",   bus_b.ovf_o,   4'b0100);
    chk("sat_cyc_hold", bus_b.cycle_o, 255);
    step(44);
    bus_b.event_i = 4'b0000;
    bus_b.sel_i = 2; step(1); chk("sat_ch2", bus_b.rd_data_o, 255);
    bus_b.sel_i = 4; step(1); chk("sat_cycrd", bus_b.rd_data_o, 255);
    chk("sat_ovf_sticky", bus_b.ovf_o,     4'b0100);
    chk("sat_running",    bus_b.running_o, 1);
    bus_b.clear_i = 1;
    step(1);
    bus_b.clear_i = 0;
    chk("sat_clr_ovf",   bus_b.ovf_o,     0);
    chk("sat_clr_cycle", bus_b.cycle_o,   0);
    chk("sat_clr_run",   bus_b.running_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_event_counter.md
# pipe_event_counter

Parametrised cycle and event counter for the pipelined CPU, replacing ad-hoc stall/flush tallying with a synthesizable block. It counts up to NUM_EVENTS qualified hazard events (stall, flush, etc.) plus elapsed cycles over a bounded or unbounded run window. Counters are read back through a registered select port. It sits beside the CPU top, fed by single-bit event strobes from the hazard detection unit and the flush logic.

## Interface
- NUM_EVENTS, 4: number of event channels (1..16).
- CNT_WIDTH, 32: width of every counter, including the cycle counter (8..64).
- MAX_CYCLES, 64: run-window length in counted cycles; 0 = unlimited.
- SEL_W, clog2(NUM_EVENTS+1): read-select width (derived).
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high; highest priority.
- start_i  in  1  begin run; sampled only in IDLE.
- clear_i  in  1  zero all counters and flags, return to IDLE.
- freeze_i  in  1  pause counting in RUN (cycle and event counters hold).
- event_i  in  NUM_EVENTS  per-channel event strobe, one count per high cycle.
- mask_i  in  NUM_EVENTS  per-channel enable; event counted only if event_i[i] & mask_i[i].
- sel_i  in  SEL_W  read select: 0..NUM_EVENTS-1 = event counter, NUM_EVENTS = cycle counter, above = 0.
- rd_data_o  out  CNT_WIDTH  registered readout of selected counter.
- cycle_o  out  CNT_WIDTH  live cycle counter.
- running_o  out  1  state == RUN.
- done_o  out  1  state == DONE.
- ovf_o  out  NUM_EVENTS  sticky per-channel saturation flag.

## Operation
- States: IDLE (reset state), RUN, DONE.
  - IDLE: start_i=1 moves to RUN. Nothing is counted on that edge.
  - RUN: each edge with freeze_i=0 is a counted cycle.
  - RUN → DONE on the edge where the cycle counter reaches MAX_CYCLES (MAX_CYCLES≠0).
  - DONE: all counters hold; start_i is ignored.
- Counted cycle:
  - cycle counter +1.
  - Channel i +1 if event_i[i] & mask_i[i].
  - Events on the final (DONE-entering) edge are counted.
- Saturation:
  - An event counter at all-ones stays all-ones; a further qualified event sets ovf_o[i], which is sticky until clear/reset.
  - The cycle counter saturates at all-ones when MAX_CYCLES=0. It raises no flag.
- Priority: rst_i > clear_i > state transitions/counting.
  - clear_i in any state zeroes all counters and ovf_o and forces IDLE. Any start_i on that edge is ignored.
- start_i is ignored while in RUN or DONE.
- freeze_i affects only the RUN state; events during a frozen cycle are dropped, not deferred.
- Readout: rd_data_o ← counter[sel_i] every edge, regardless of state. The read reflects counter values before that edge's update.
- Reset values: state IDLE; all counters 0; rd_data_o 0; cycle_o 0; running_o 0; done_o 0; ovf_o 0.

## Timing
- Counter update latency: an event at edge k is visible on cycle_o/internal counters after edge k.
- rd_data_o latency: 1 cycle from sel_i. An update at edge k is visible on rd_data_o after edge k+1 with the same sel_i.
- Window boundaries (MAX_CYCLES=M):
  - Start seen at edge s; counted edges are s+1..s+M (no freeze).
  - done_o rises after edge s+M.
  - cycle_o = M in DONE.
- Freeze extends the window one edge per frozen cycle.
- running_o, done_o and ovf_o are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-run: MAX_CYCLES=64. Start, count 10 cycles with event_i=4'b0001, assert rst_i one edge -> all outputs 0, state IDLE; following start re-counts from 0.
- Full window:
  - MAX_CYCLES=64, mask=4'b1111.
  - event_i[0] high every cycle, event_i[1] high every other cycle.
  - Required: done_o after 64 counted edges; cycle_o=64; sel 0 reads 64; sel 1 reads 32; sel 4 reads 64; sel 5 reads 0.
- Mask and freeze:
  - Stimulus: mask=4'b0010, event_i=4'b0011 for 20 cycles, freeze_i high for 5 of them.
  - Required: channel 0 = 0, channel 1 = 15, cycle_o = 15, done_o still 0.
- Saturation: CNT_WIDTH=8, MAX_CYCLES=0, event_i[2] high 300 cycles -> channel 2 reads 255, ovf_o[2]=1 from the 256th event; cycle counter reads 255; ovf_o stays set until clear_i.
- Simultaneous clear+start in DONE -> IDLE, counters 0, running_o=0. A start_i one cycle later -> RUN.
- Readout latency: change sel_i from 0 to 1 in DONE -> rd_data_o shows channel 1 exactly one edge later. Counters unchanged by further events.
